// File: rtl/data_memory_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_bus_ctrl
//  Description : Load/store bus controller with a data-memory window and an
//                MMIO window with wait states, timeout and error responses.
//  Revision    : 2.0 - valid/ready handshake, lane steering, MMIO window
// ============================================================================
module data_memory_bus_ctrl #(
    parameter logic [31:0] DATA_BEGIN   = 32'h0000_2000,
    parameter logic [31:0] DATA_END     = 32'h0000_3FFF,
    parameter int          DATA_BITS    = 13,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] MMIO_BEGIN   = 32'h0001_0000,
    parameter logic [31:0] MMIO_END     = 32'h0001_FFFF,
    parameter int          MMIO_TIMEOUT = 15
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [31:0]            req_address,
    input  logic                   req_write,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [31:0]            req_write_data,
    output logic                   resp_valid,
    output logic [31:0]            resp_read_data,
    output logic                   resp_error,
    output logic [DATA_BITS-3:0]   mem_address,
    output logic [3:0]             mem_byteena,
    output logic [31:0]            mem_data,
    output logic                   mem_wren,
    input  logic [31:0]            mem_q,
    output logic                   mmio_valid,
    input  logic                   mmio_ready,
    output logic [31:0]            mmio_address,
    output logic                   mmio_write,
    output logic [3:0]             mmio_byteena,
    output logic [31:0]            mmio_write_data,
    input  logic [31:0]            mmio_read_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_MMIO = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [7:0] c_read_wait    = 8'(READ_LATENCY - 1);
    localparam logic [7:0] c_timeout_last = 8'(MMIO_TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_count;
    logic        r_write;
    logic [1:0]  r_size;
    logic [1:0]  r_offset;
    logic        r_unsigned;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_in_data;
    logic        w_in_mmio;
    logic [3:0]  w_byteena;
    logic [31:0] w_store_data;
    logic [31:0] w_mem_load;
    logic [31:0] w_mmio_load;

    // Pick the addressed lane from a full word, then sign/zero extend.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  offset,
                                                input logic [1:0]  size,
                                                input logic        zero_ext);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] result;
        case (offset)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = offset[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    result = zero_ext ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'd1:    result = zero_ext ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: result = word;
        endcase
        return result;
    endfunction

    assign w_accept     = req_valid & req_ready;
    assign w_misaligned = (req_size == 2'd3)
                        | ((req_size == 2'd1) & req_address[0])
                        | ((req_size == 2'd2) & (|req_address[1:0]));
    assign w_in_data    = (req_address >= DATA_BEGIN) && (req_address <= DATA_END);
    assign w_in_mmio    = (req_address >= MMIO_BEGIN) && (req_address <= MMIO_END);
    assign w_mem_load   = load_extend(mem_q, r_offset, r_size, r_unsigned);
    assign w_mmio_load  = load_extend(mmio_read_data, r_offset, r_size, r_unsigned);

    always_comb begin
        w_byteena    = 4'b1111;
        w_store_data = req_write_data;
        case (req_size)
            2'd0: begin
                w_byteena    = 4'b0001 << req_address[1:0];
                w_store_data = {4{req_write_data[7:0]}};
            end
            2'd1: begin
                w_byteena    = req_address[1] ? 4'b1100 : 4'b0011;
                w_store_data = {2{req_write_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_count         <= 8'd0;
            r_write         <= 1'b0;
            r_size          <= 2'd0;
            r_offset        <= 2'd0;
            r_unsigned      <= 1'b0;
            req_ready       <= 1'b0;
            resp_valid      <= 1'b0;
            resp_read_data  <= 32'd0;
            resp_error      <= 1'b0;
            mem_address     <= '0;
            mem_byteena     <= 4'd0;
            mem_data        <= 32'd0;
            mem_wren        <= 1'b0;
            mmio_valid      <= 1'b0;
            mmio_address    <= 32'd0;
            mmio_write      <= 1'b0;
            mmio_byteena    <= 4'd0;
            mmio_write_data <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        req_ready  <= 1'b0;
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_offset   <= req_address[1:0];
                        r_unsigned <= req_unsigned;
                        if (w_misaligned || !(w_in_data || w_in_mmio)) begin
                            r_state        <= S_RESP;
                            resp_valid     <= 1'b1;
                            resp_error     <= 1'b1;
                            resp_read_data <= 32'd0;
                        end else if (w_in_data) begin
                            r_state     <= S_MEM;
                            r_count     <= c_read_wait;
                            mem_address <= req_address[DATA_BITS-1:2];
                            mem_byteena <= w_byteena;
                            mem_data    <= w_store_data;
                            mem_wren    <= req_write;
                        end else begin
                            r_state         <= S_MMIO;
                            r_count         <= 8'd0;
                            mmio_valid      <= 1'b1;
                            mmio_address    <= req_address;
                            mmio_write      <= req_write;
                            mmio_byteena    <= w_byteena;
                            mmio_write_data <= w_store_data;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_MEM: begin
                    mem_wren <= 1'b0;
                    // Stores complete after the single write cycle.
                    if (r_write || (r_count == 8'd0)) begin
                        r_state        <= S_RESP;
                        resp_valid     <= 1'b1;
                        resp_error     <= 1'b0;
                        resp_read_data <= r_write ? 32'd0 : w_mem_load;
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                S_MMIO: begin
                    if (mmio_ready) begin
                        r_state        <= S_RESP;
                        mmio_valid     <= 1'b0;
                        resp_valid     <= 1'b1;
                        resp_error     <= 1'b0;
                        resp_read_data <= r_write ? 32'd0 : w_mmio_load;
                    end else if (r_count == c_timeout_last) begin
                        r_state        <= S_RESP;
                        mmio_valid     <= 1'b0;
                        resp_valid     <= 1'b1;
                        resp_error     <= 1'b1;
                        resp_read_data <= 32'd0;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                S_RESP: begin
                    r_state        <= S_IDLE;
                    resp_valid     <= 1'b0;
                    resp_error     <= 1'b0;
                    resp_read_data <= 32'd0;
                    req_ready      <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_bus_ctrl.sv
`default_nettype none
// Directed testbench for data_memory_bus_ctrl: one instance at READ_LATENCY=1,
// a second at READ_LATENCY=3 for latency and mid-transaction reset.
module tb_data_memory_bus_ctrl;

    logic        clock;
    logic        reset;
    int          checks;
    int          errors;

    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [31:0] req_address, req_write_data;
    logic [1:0]  req_size;
    logic        resp_valid, resp_error;
    logic [31:0] resp_read_data;
    logic [10:0] mem_address;
    logic [3:0]  mem_byteena;
    logic [31:0] mem_data, mem_q;
    logic        mem_wren;
    logic        mmio_valid, mmio_ready, mmio_write;
    logic [31:0] mmio_address, mmio_write_data, mmio_read_data;
    logic [3:0]  mmio_byteena;

    logic        req_valid3, req_ready3, req_write3, req_unsigned3;
    logic [31:0] req_address3, req_write_data3;
    logic [1:0]  req_size3;
    logic        resp_valid3, resp_error3;
    logic [31:0] resp_read_data3;
    logic [10:0] mem_address3;
    logic [3:0]  mem_byteena3;
    logic [31:0] mem_data3, mem_q3;
    logic        mem_wren3;
    logic        mmio_valid3, mmio_ready3, mmio_write3;
    logic [31:0] mmio_address3, mmio_write_data3, mmio_read_data3;
    logic [3:0]  mmio_byteena3;

    data_memory_bus_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_write_data(req_write_data), .resp_valid(resp_valid),
        .resp_read_data(resp_read_data), .resp_error(resp_error),
        .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q), .mmio_valid(mmio_valid),
        .mmio_ready(mmio_ready), .mmio_address(mmio_address), .mmio_write(mmio_write),
        .mmio_byteena(mmio_byteena), .mmio_write_data(mmio_write_data),
        .mmio_read_data(mmio_read_data)
    );

    data_memory_bus_ctrl #(.READ_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_address(req_address3),
        .req_write(req_write3), .req_size(req_size3), .req_unsigned(req_unsigned3),
        .req_write_data(req_write_data3), .resp_valid(resp_valid3),
        .resp_read_data(resp_read_data3), .resp_error(resp_error3),
        .mem_address(mem_address3), .mem_byteena(mem_byteena3), .mem_data(mem_data3),
        .mem_wren(mem_wren3), .mem_q(mem_q3), .mmio_valid(mmio_valid3),
        .mmio_ready(mmio_ready3), .mmio_address(mmio_address3), .mmio_write(mmio_write3),
        .mmio_byteena(mmio_byteena3), .mmio_write_data(mmio_write_data3),
        .mmio_read_data(mmio_read_data3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one request; returns in cycle T+1 with req_valid dropped.
    task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] s,
                         input logic u, input logic [31:0] d);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL issue_ready got %b need 1", req_ready); end
        req_valid = 1'b1; req_address = a; req_write = w; req_size = s;
        req_unsigned = u; req_write_data = d;
        step();
        req_valid = 1'b0;
    endtask

    task automatic issue3(input logic [31:0] a);
        int n;
        n = 0;
        while (req_ready3 !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (req_ready3 !== 1'b1) begin errors++; $display("FAIL issue3_ready got %b need 1", req_ready3); end
        req_valid3 = 1'b1; req_address3 = a; req_write3 = 1'b0; req_size3 = 2'd2;
        req_unsigned3 = 1'b0; req_write_data3 = 32'd0;
        step();
        req_valid3 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b need 0", req_ready); end
        checks++; if ({resp_valid, resp_error, mem_wren, mmio_valid} !== 4'b0000) begin errors++; $display("FAIL rst_ctrl got %b need 0000", {resp_valid, resp_error, mem_wren, mmio_valid}); end
        checks++; if ({mem_address, mem_byteena, mmio_address} !== 47'd0) begin errors++; $display("FAIL rst_fields got %h need 0", {mem_address, mem_byteena, mmio_address}); end
        step(); step();
        reset = 1'b1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready got %b need 0", req_ready); end
        step();
        checks++; if ({req_ready, req_ready3} !== 2'b11) begin errors++; $display("FAIL rst_first_edge_ready got %b need 11", {req_ready, req_ready3}); end
    endtask

    task automatic test_word_store_load();
        issue(32'h2004, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF);
        checks++; if (mem_wren !== 1'b1) begin errors++; $display("FAIL st_wren got %b need 1", mem_wren); end
        checks++; if (mem_address !== 11'd1) begin errors++; $display("FAIL st_addr got %h need 001", mem_address); end
        checks++; if (mem_byteena !== 4'b1111) begin errors++; $display("FAIL st_be got %b need 1111", mem_byteena); end
        checks++; if (mem_data !== 32'hDEADBEEF) begin errors++; $display("FAIL st_data got %h need deadbeef", mem_data); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL st_early_resp got %b need 0", resp_valid); end
        step();
        checks++; if ({resp_valid, resp_error, mem_wren} !== 3'b100) begin errors++; $display("FAIL st_resp got %b need 100", {resp_valid, resp_error, mem_wren}); end
        step();
        checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL st_after got %b need 01", {resp_valid, req_ready}); end

        mem_q = 32'hDEADBEEF;
        issue(32'h2004, 1'b0, 2'd2, 1'b0, 32'd0);
        checks++; if ({mem_wren, resp_valid, req_ready} !== 3'b000) begin errors++; $display("FAIL ld_t1 got %b need 000", {mem_wren, resp_valid, req_ready}); end
        checks++; if (mem_address !== 11'd1) begin errors++; $display("FAIL ld_addr got %h need 001", mem_address); end
        step();
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL ld_valid got %b need 1", resp_valid); end
        checks++; if (resp_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_data got %h need deadbeef", resp_read_data); end
        step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL ld_single_pulse got %b need 0", resp_valid); end
    endtask

    task automatic test_subword();
        mem_q = 32'h80FF_0000;
        issue(32'h2007, 1'b0, 2'd0, 1'b0, 32'd0);
        step();
        checks++; if (resp_read_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_signed got %h need ffffff80", resp_read_data); end
        issue(32'h2007, 1'b0, 2'd0, 1'b1, 32'd0);
        step();
        checks++; if (resp_read_data !== 32'h0000_0080) begin errors++; $display("FAIL lb_unsigned got %h need 00000080", resp_read_data); end
        issue(32'h2006, 1'b0, 2'd1, 1'b0, 32'd0);
        step();
        checks++; if (resp_read_data !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_signed got %h need ffff80ff", resp_read_data); end

        issue(32'h2002, 1'b1, 2'd1, 1'b0, 32'h0000_A5C3);
        checks++; if (mem_byteena !== 4'b1100) begin errors++; $display("FAIL sh_be got %b need 1100", mem_byteena); end
        checks++; if (mem_data !== 32'hA5C3_A5C3) begin errors++; $display("FAIL sh_data got %h need a5c3a5c3", mem_data); end
        checks++; if ({mem_wren, mem_address} !== {1'b1, 11'd0}) begin errors++; $display("FAIL sh_wren_addr got %h need 800", {mem_wren, mem_address}); end
        step();
    endtask

    task automatic test_errors();
        issue(32'h2001, 1'b0, 2'd2, 1'b0, 32'd0);
        checks++; if ({resp_valid, resp_error} !== 2'b11) begin errors++; $display("FAIL mis_resp got %b need 11", {resp_valid, resp_error}); end
        checks++; if ({mem_wren, mmio_valid, resp_read_data} !== 34'd0) begin errors++; $display("FAIL mis_side got %h need 0", {mem_wren, mmio_valid, resp_read_data}); end
        step();
        issue(32'h0000_8000, 1'b1, 2'd2, 1'b0, 32'h1111_1111);
        checks++; if ({resp_valid, resp_error} !== 2'b11) begin errors++; $display("FAIL unmap_resp got %b need 11", {resp_valid, resp_error}); end
        checks++; if ({mem_wren, mmio_valid} !== 2'b00) begin errors++; $display("FAIL unmap_side got %b need 00", {mem_wren, mmio_valid}); end
        step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL err_single_pulse got %b need 0", resp_valid); end
    endtask

    task automatic test_mmio();
        int hi;
        int n;
        mmio_ready = 1'b1;
        step(); step();
        checks++; if ({mmio_valid, resp_valid, req_ready} !== 3'b001) begin errors++; $display("FAIL mmio_idle_ready got %b need 001", {mmio_valid, resp_valid, req_ready}); end
        mmio_ready = 1'b0;

        issue(32'h0001_0010, 1'b0, 2'd2, 1'b0, 32'd0);
        checks++; if ({mmio_valid, mmio_write, mmio_byteena} !== 6'b101111) begin errors++; $display("FAIL mmio_req got %b need 101111", {mmio_valid, mmio_write, mmio_byteena}); end
        checks++; if (mmio_address !== 32'h0001_0010) begin errors++; $display("FAIL mmio_addr got %h need 00010010", mmio_address); end
        for (int i = 0; i < 3; i++) begin
            checks++; if ({mmio_valid, resp_valid} !== 2'b10) begin errors++; $display("FAIL mmio_wait%0d got %b need 10", i, {mmio_valid, resp_valid}); end
            step();
        end
        mmio_ready = 1'b1; mmio_read_data = 32'h1234_5678;
        checks++; if (mmio_valid !== 1'b1) begin errors++; $display("FAIL mmio_hold got %b need 1", mmio_valid); end
        step();
        mmio_ready = 1'b0; mmio_read_data = 32'd0;
        checks++; if ({resp_valid, resp_error, mmio_valid} !== 3'b100) begin errors++; $display("FAIL mmio_resp got %b need 100", {resp_valid, resp_error, mmio_valid}); end
        checks++; if (resp_read_data !== 32'h1234_5678) begin errors++; $display("FAIL mmio_data got %h need 12345678", resp_read_data); end
        step();

        issue(32'h0001_0013, 1'b1, 2'd0, 1'b0, 32'h0000_005A);
        checks++; if ({mmio_write, mmio_byteena} !== 5'b11000) begin errors++; $display("FAIL mmio_sb_be got %b need 11000", {mmio_write, mmio_byteena}); end
        checks++; if (mmio_write_data !== 32'h5A5A_5A5A) begin errors++; $display("FAIL mmio_sb_data got %h need 5a5a5a5a", mmio_write_data); end
        mmio_ready = 1'b1;
        step();
        mmio_ready = 1'b0;
        checks++; if ({resp_valid, resp_error, resp_read_data} !== {2'b10, 32'd0}) begin errors++; $display("FAIL mmio_sb_resp got %h need 200000000", {resp_valid, resp_error, resp_read_data}); end
        step();

        issue(32'h0001_0010, 1'b0, 2'd2, 1'b0, 32'd0);
        hi = 0; n = 0;
        while (resp_valid !== 1'b1 && n < 40) begin
            if (mmio_valid === 1'b1) hi++;
            step(); n++;
        end
        checks++; if (hi != 15) begin errors++; $display("FAIL tmo_cycles got %0d need 15", hi); end
        checks++; if ({resp_valid, resp_error, mmio_valid} !== 3'b110) begin errors++; $display("FAIL tmo_resp got %b need 110", {resp_valid, resp_error, mmio_valid}); end
        checks++; if (resp_read_data !== 32'd0) begin errors++; $display("FAIL tmo_data got %h need 0", resp_read_data); end
        step();
    endtask

    task automatic test_latency_reset();
        logic seen;
        mem_q3 = 32'hCAFE_F00D;
        issue3(32'h2008);
        for (int i = 0; i < 3; i++) begin
            checks++; if ({resp_valid3, req_ready3} !== 2'b00) begin errors++; $display("FAIL lat3_wait%0d got %b need 00", i, {resp_valid3, req_ready3}); end
            step();
        end
        checks++; if (resp_valid3 !== 1'b1) begin errors++; $display("FAIL lat3_valid got %b need 1", resp_valid3); end
        checks++; if (resp_read_data3 !== 32'hCAFE_F00D) begin errors++; $display("FAIL lat3_data got %h need cafef00d", resp_read_data3); end
        step();

        issue3(32'h2008);
        step();
        reset = 1'b0;
        #1;
        checks++; if ({req_ready3, resp_valid3, mem_address3} !== 13'd0) begin errors++; $display("FAIL rst_mid got %h need 0", {req_ready3, resp_valid3, mem_address3}); end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); if (resp_valid3 === 1'b1) seen = 1'b1; end
        reset = 1'b1;
        checks++; if (req_ready3 !== 1'b0) begin errors++; $display("FAIL rst_mid_release got %b need 0", req_ready3); end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                checks++; if (req_ready3 !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b need 1", req_ready3); end
            end
            step();
            if (resp_valid3 === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_noresp got %b need 0", seen); end
    endtask

    initial begin
        checks = 0; errors = 0;
        req_valid = 0; req_address = 0; req_write = 0; req_size = 0; req_unsigned = 0;
        req_write_data = 0; mem_q = 0; mmio_ready = 0; mmio_read_data = 0;
        req_valid3 = 0; req_address3 = 0; req_write3 = 0; req_size3 = 0; req_unsigned3 = 0;
        req_write_data3 = 0; mem_q3 = 0; mmio_ready3 = 0; mmio_read_data3 = 0;
        test_reset();
        test_word_store_load();
        test_subword();
        test_errors();
        test_mmio();
        test_latency_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
